// File: rtl/udma_pwr_seq.sv
// Per-peripheral clock-gate / reset-release sequencer for the uDMA channels.
// Optional macro UDMA_PWR_SEQ_RETARGET_EN: accept a new target vector while busy.
module udma_pwr_seq #(
    parameter int unsigned N_PERIPHS  = 6,
    parameter int unsigned SETTLE_CYC = 4
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,
    input  logic                 target_valid_i,
    input  logic [N_PERIPHS-1:0] target_i,
    output logic                 target_ready_o,
    output logic [N_PERIPHS-1:0] cg_value_o,
    output logic [N_PERIPHS-1:0] rst_value_o,
    output logic                 cg_core_o,
    output logic                 busy_o,
    output logic                 done_evt_o
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SCAN    = 2'd1,
        ST_UP_WAIT = 2'd2,
        ST_DN_WAIT = 2'd3
    } state_e;

    localparam logic [7:0]           CNT_LOAD = 8'(SETTLE_CYC - 32'd1);
    localparam logic [N_PERIPHS-1:0] LSB_ONE  = N_PERIPHS'(1'b1);

    state_e                 state_q, state_d;
    logic [N_PERIPHS-1:0]   tgt_q, tgt_d;
    logic [N_PERIPHS-1:0]   cg_q, cg_d;
    logic [N_PERIPHS-1:0]   rst_q, rst_d;
    logic [N_PERIPHS-1:0]   sel_q, sel_d;
    logic [7:0]             cnt_q, cnt_d;
    logic                   done_q, done_d;

    logic                   ready_s;
    logic                   accept_s;
    logic [N_PERIPHS-1:0]   on_s;
    logic [N_PERIPHS-1:0]   diff_s;
    logic [N_PERIPHS-1:0]   lowest_s;

`ifdef UDMA_PWR_SEQ_RETARGET_EN
    assign ready_s = 1'b1;
`else
    assign ready_s = (state_q == ST_IDLE);
`endif

    assign accept_s = target_valid_i & ready_s;

    // A half-sequenced bit (clock on, still in reset) counts as off.
    assign on_s     = cg_q & ~rst_q;
    assign diff_s   = tgt_q ^ on_s;
    // Isolate the lowest mismatching channel (two's-complement trick).
    assign lowest_s = diff_s & (~diff_s + LSB_ONE);

    // Next-state, target latch and output-edge decisions.
    always_comb begin
        state_d = state_q;
        cg_d    = cg_q;
        rst_d   = rst_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;

        if (accept_s) begin
            tgt_d = target_i;
        end else begin
            tgt_d = tgt_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    state_d = ST_SCAN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SCAN: begin
                if (|diff_s) begin
                    sel_d = lowest_s;
                    cnt_d = CNT_LOAD;
                    if (|(tgt_q & lowest_s)) begin
                        cg_d    = cg_q | lowest_s;
                        state_d = ST_UP_WAIT;
                    end else begin
                        rst_d   = rst_q | lowest_s;
                        state_d = ST_DN_WAIT;
                    end
                end else begin
                    done_d = 1'b1;
                    // A target taken in this same cycle still needs a scan.
                    if (accept_s) begin
                        state_d = ST_SCAN;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_UP_WAIT: begin
                if (cnt_q == 8'd0) begin
                    rst_d   = rst_q & ~sel_q;
                    state_d = ST_SCAN;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            ST_DN_WAIT: begin
                if (cnt_q == 8'd0) begin
                    cg_d    = cg_q & ~sel_q;
                    state_d = ST_SCAN;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_q <= ST_IDLE;
            tgt_q   <= '0;
            cg_q    <= '0;
            rst_q   <= '1;
            sel_q   <= '0;
            cnt_q   <= 8'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tgt_q   <= tgt_d;
            cg_q    <= cg_d;
            rst_q   <= rst_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    assign target_ready_o = ready_s;
    assign cg_value_o     = cg_q;
    assign rst_value_o    = rst_q;
    assign cg_core_o      = |cg_q;
    assign busy_o         = (state_q != ST_IDLE);
    assign done_evt_o     = done_q;

endmodule

// File: tb/tb_udma_pwr_seq.sv
// Self-checking bench for udma_pwr_seq: vector table, corner sequences and
// randomized targets checked cycle by cycle against a trace-building model.
module tb_udma_pwr_seq;
    localparam int N = 6;
    localparam int S = 4;
    localparam int W = 2 * N + 4;

    logic         clk_i = 1'b0;
    logic         rstn_i = 1'b0;
    logic         target_valid_i = 1'b0;
    logic [N-1:0] target_i = '0;
    logic         target_ready_o;
    logic [N-1:0] cg_value_o;
    logic [N-1:0] rst_value_o;
    logic         cg_core_o;
    logic         busy_o;
    logic         done_evt_o;

    int errors = 0;
    int checks = 0;

    logic [N-1:0] m_cg;
    logic [N-1:0] m_rst;
    logic [W-1:0] trace[$];

    typedef struct {
        logic [N-1:0] tgt;
        logic [N-1:0] cg;
        logic [N-1:0] rst;
        int           lat;
    } vec_t;
    vec_t tbl[5];

    always #5 clk_i = ~clk_i;

    udma_pwr_seq #(.N_PERIPHS(N), .SETTLE_CYC(S)) dut (
        .clk_i          (clk_i),
        .rstn_i         (rstn_i),
        .target_valid_i (target_valid_i),
        .target_i       (target_i),
        .target_ready_o (target_ready_o),
        .cg_value_o     (cg_value_o),
        .rst_value_o    (rst_value_o),
        .cg_core_o      (cg_core_o),
        .busy_o         (busy_o),
        .done_evt_o     (done_evt_o)
    );

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    function automatic logic [W-1:0] pack(input logic [N-1:0] cg, input logic [N-1:0] rst,
                                          input logic busy, input logic done);
        logic rdy;
`ifdef UDMA_PWR_SEQ_RETARGET_EN
        rdy = 1'b1;
`else
        rdy = ~busy;
`endif
        return {cg, rst, busy, done, |cg, rdy};
    endfunction

    function automatic logic [W-1:0] observe();
        return {cg_value_o, rst_value_o, busy_o, done_evt_o, cg_core_o, target_ready_o};
    endfunction

    // Expected per-cycle outputs from A+1 onward: every mismatching channel in
    // ascending order costs S cycles after its first edge plus one scan cycle.
    task automatic build_trace(input logic [N-1:0] tgt);
        logic [N-1:0] on;
        trace.delete();
        trace.push_back(pack(m_cg, m_rst, 1'b1, 1'b0));
        for (int i = 0; i < N; i++) begin
            on = m_cg & ~m_rst;
            if (tgt[i] != on[i]) begin
                if (tgt[i]) m_cg[i] = 1'b1;
                else        m_rst[i] = 1'b1;
                repeat (S) trace.push_back(pack(m_cg, m_rst, 1'b1, 1'b0));
                if (tgt[i]) m_rst[i] = 1'b0;
                else        m_cg[i] = 1'b0;
                trace.push_back(pack(m_cg, m_rst, 1'b1, 1'b0));
            end
        end
        trace.push_back(pack(m_cg, m_rst, 1'b0, 1'b1));
        trace.push_back(pack(m_cg, m_rst, 1'b0, 1'b0));
    endtask

    // Accept tgt, then compare every cycle; optionally offer inj_tgt at A+inj.
    task automatic run_txn(input logic [N-1:0] tgt, input int inj, input logic [N-1:0] inj_tgt,
                           input string name);
        check({name, "_rdy"}, 0, 32'(target_ready_o), 32'd1);
        target_i = tgt;
        target_valid_i = 1'b1;
        build_trace(tgt);
        step();
        for (int k = 0; k < trace.size(); k++) begin
            target_valid_i = 1'b0;
            target_i = N'($urandom);
            if (k + 1 == inj) begin
                target_valid_i = 1'b1;
                target_i = inj_tgt;
                check({name, "_stall_rdy"}, k + 1, 32'(target_ready_o), 32'd0);
            end
            check(name, k + 1, 32'(observe()), 32'(trace[k]));
            step();
        end
        target_valid_i = 1'b0;
    endtask

    initial begin
        int n;
        int inj;
        tbl[0] = '{6'b000101, 6'b000101, 6'b111010, 12};
        tbl[1] = '{6'b000001, 6'b000001, 6'b111110, 7};
        tbl[2] = '{6'b000001, 6'b000001, 6'b111110, 2};
        tbl[3] = '{6'b111110, 6'b111110, 6'b000001, 32};
        tbl[4] = '{6'b000000, 6'b000000, 6'b111111, 27};

        // Reset state
        rstn_i = 1'b0;
        repeat (3) step();
        rstn_i = 1'b1;
        check("reset", 0, 32'(observe()), 32'(pack(6'h00, 6'h3F, 1'b0, 1'b0)));
        step();
        check("reset", 1, 32'(observe()), 32'(pack(6'h00, 6'h3F, 1'b0, 1'b0)));

        // Vector table: final state and accept-to-done latency
        foreach (tbl[j]) begin
            target_i = tbl[j].tgt;
            target_valid_i = 1'b1;
            step();
            target_valid_i = 1'b0;
            n = 1;
            while (!done_evt_o && n < 100) begin
                step();
                n++;
            end
            check("tbl_lat", j, 32'(n), 32'(tbl[j].lat));
            check("tbl_cg", j, 32'(cg_value_o), 32'(tbl[j].cg));
            check("tbl_rst", j, 32'(rst_value_o), 32'(tbl[j].rst));
            step();
        end
        m_cg = 6'h00;
        m_rst = 6'h3F;

        // Reset in the middle of a power-up, then re-issue from bit 0
        target_i = 6'b000101;
        target_valid_i = 1'b1;
        step();
        target_valid_i = 1'b0;
        repeat (3) step();
        rstn_i = 1'b0;
        step();
        rstn_i = 1'b1;
        check("midrst", 0, 32'(observe()), 32'(pack(6'h00, 6'h3F, 1'b0, 1'b0)));
        run_txn(6'b000101, -1, 6'h00, "restart");
        run_txn(6'b000000, -1, 6'h00, "alloff");

        // Valid while busy at A+4
`ifdef UDMA_PWR_SEQ_RETARGET_EN
        target_i = 6'b000101;
        target_valid_i = 1'b1;
        step();
        target_valid_i = 1'b0;
        n = 1;
        while (n < 4) begin
            step();
            n++;
        end
        target_i = 6'h3F;
        target_valid_i = 1'b1;
        check("rt_rdy", n, 32'(target_ready_o), 32'd1);
        step();
        target_valid_i = 1'b0;
        step();
        n = 6;
        check("rt_a6", n, 32'({cg_value_o, rst_value_o}), 32'({6'b000001, 6'b111110}));
        step();
        n = 7;
        check("rt_a7", n, 32'({cg_value_o, rst_value_o}), 32'({6'b000011, 6'b111110}));
        while (!done_evt_o && n < 100) begin
            step();
            n++;
        end
        check("rt_lat", 0, 32'(n), 32'd32);
        check("rt_final", 0, 32'({cg_value_o, rst_value_o}), 32'({6'h3F, 6'h00}));
        step();
        m_cg = 6'h3F;
        m_rst = 6'h00;
`else
        run_txn(6'b000101, 4, 6'h3F, "stall");
`endif

        // Power-down one bit, then a no-change target
        run_txn(6'b000001, -1, 6'h00, "pdown");
        run_txn(6'b000001, -1, 6'h00, "nochg");

        // Randomized targets against the model
        for (int t = 0; t < 30; t++) begin
`ifdef UDMA_PWR_SEQ_RETARGET_EN
            inj = -1;
`else
            inj = ($urandom_range(0, 1) == 1) ? int'($urandom_range(2, 12)) : -1;
`endif
            run_txn(N'($urandom), inj, N'($urandom), "rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
